mem_stage: RTL and testbench
============================

# mem_stage

EX/MEM pipeline register plus memory-access stage and MEM/WB pipeline register for the 5-stage pipelined core. It receives EX results, performs LW/SW through a req/ack data-memory port with wait states, and drives the EX_MEM_* / MEM_WB_* signals that the EX-stage forwarding unit consumes. While a memory access is outstanding it asserts `mem_stall` to freeze IF/ID/EX.

## Interface
- `TIMEOUT`, default 16: maximum number of ACCESS cycles without `dmem_ack` before the access is aborted.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `ex_valid`  in  1  EX holds a valid instruction.
- `ex_aluop`  in  5  ALU opcode; LW=5'b10100, SW=5'b10101, all others non-memory.
- `ex_result`  in  32  ALU result; this is the address for LW/SW.
- `ex_store_data`  in  32  forwarded rs2 value for SW.
- `ex_rd`  in  5  destination register.
- `ex_regwrite`  in  1  instruction writes rd.
- `mem_stall`  out  1  freeze upstream stages; EX inputs are ignored while high.
- `ex_mem_rd`, `ex_mem_regwrite`, `ex_mem_aluresult`  out  5/1/32  forwarding source from EX/MEM.
- `ex_mem_is_load`  out  1  EX/MEM holds a valid LW; used by the hazard unit for load-use stalls.
- `mem_wb_rd`, `mem_wb_regwrite`, `mem_wb_data`  out  5/1/32  writeback and forwarding source from MEM/WB.
- `dmem_req`, `dmem_we`  out  1/1  memory request and write enable.
- `dmem_addr`, `dmem_wdata`  out  32/32  word address (byte-addressed, aligned) and store data.
- `dmem_rdata`  in  32  load data; valid in the cycle `dmem_ack` is high.
- `dmem_ack`  in  1  completes the current request.
- `mem_fault`  out  1  sticky flag for misaligned access or timeout; cleared only by `rst`.

## Operation
- **EX/MEM capture.** On each edge where `mem_stall`=0, capture valid, op, result, store data, rd, and regwrite.
  - Stored regwrite = `ex_regwrite & ex_valid & (ex_rd!=0)`.
  - Stored regwrite is forced to 0 for SW.
- **FSM.** Two states, IDLE and ACCESS.
  - **Entry:** go from IDLE to ACCESS on the same edge that captures a valid LW/SW whose `ex_result[1:0]==0`.
  - **In ACCESS:**
    - `dmem_req`=1.
    - `dmem_we` = (op==SW).
    - `dmem_addr` = `ex_mem_aluresult`.
    - `dmem_wdata` = stored store data.
  - **On ack:**
    - `dmem_ack`=1 in ACCESS leads to IDLE.
    - The MEM/WB register captures `dmem_rdata` for LW.
  - **On timeout:** the wait counter reaches `TIMEOUT-1` with no ack.
    - Go to IDLE and set `mem_fault`.
    - The MEM/WB entry becomes a bubble (regwrite=0).
  - **Misaligned:** a misaligned LW/SW issues no request, sets `mem_fault`, and writes back nothing (regwrite=0).
- **Stall.** `mem_stall` = (state==ACCESS) & !`dmem_ack` & !timeout_now. It is combinational, so a zero-wait memory never stalls.
- **MEM/WB update, every edge:**
  - while stalled: bubble (regwrite=0, rd and data hold);
  - otherwise: rd and regwrite from EX/MEM; data = `dmem_rdata` for LW, else `ex_mem_aluresult`.
- **EX_MEM_* outputs during stall.** They hold the stalled instruction's values. EX must not use `ex_mem_aluresult` of a load as load data; `ex_mem_is_load` exposes that case.
- **Wait counter.** Width is $clog2(`TIMEOUT`). It clears on entry to ACCESS and never wraps.

## Timing
- **Reset values:** all outputs 0, state IDLE, counter 0, `mem_fault` 0.
  - `rst` mid-ACCESS drops `dmem_req` on the next cycle.
  - The outstanding access is abandoned, and a late ack in IDLE is ignored.
- **Non-memory op:** captured at edge N, visible on EX_MEM_* in cycle N, on MEM_WB_* in cycle N+1.
- **LW with k wait cycles (ack in the k-th cycle of ACCESS, k≥0):**
  - `mem_stall` is high for cycles N..N+k-1;
  - MEM/WB is valid at N+k+1.
- **Request stability:** `dmem_req`/`addr`/`we`/`wdata` remain stable from assertion until the ack or abort cycle.
- **Simultaneous ack and timeout:** ack wins; the load completes and no fault is raised.

## Structure
- **Shared package `pipe_pkg`:**
  - opcode constants OP_LW, OP_SW, OP_ADD, etc.;
  - state enum {IDLE, ACCESS};
  - an `ex_mem_t` struct (valid, op, result, sdata, rd, regwrite).
- **Sub-module `dmem_access_fsm`:** holds the state, wait counter, req/we drive, stall and timeout generation. The pipeline registers stay in `mem_stage`.

## Test plan
- **ADD pass-through.** ADD, rd=5, result=0x0000_0007 → `ex_mem_rd`=5/`regwrite`=1 next cycle, then `mem_wb_data`=0x7, `mem_wb_regwrite`=1, no stall.
- **LW, zero wait.** LW addr=0x100, ack same cycle with rdata=0xDEADBEEF → no stall, `mem_wb_data`=0xDEADBEEF one cycle later.
- **SW, 3 wait cycles.** SW addr=0x200, data=0x1234, ack after 3 wait cycles → `mem_stall` high exactly 3 cycles, `dmem_we`=1, `wdata`=0x1234, `mem_wb_regwrite`=0.
- **Misaligned LW.** LW addr=0x102 → `dmem_req` never asserted, `mem_fault`=1, `mem_wb_regwrite`=0.
- **Timeout.** `TIMEOUT`=4, ack never arrives → stall for 3 cycles, `req` drops in cycle 4, `mem_fault`=1 sticky, no writeback; a following ADD completes normally.
- **Reset and rd=0.** `rst` during ACCESS with a late ack → all outputs 0, ack ignored. ADD with rd=0 → `regwrite`=0 at both stages.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: ALU opcodes, memory-access FSM states and the EX/MEM payload.
package pipe_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 5;
  localparam int unsigned REGW = 5;

  localparam logic [OPW-1:0] OP_ADD = 5'b00000;
  localparam logic [OPW-1:0] OP_SUB = 5'b00001;
  localparam logic [OPW-1:0] OP_AND = 5'b00010;
  localparam logic [OPW-1:0] OP_OR  = 5'b00011;
  localparam logic [OPW-1:0] OP_LW  = 5'b10100;
  localparam logic [OPW-1:0] OP_SW  = 5'b10101;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] sdata;
    logic [REGW-1:0] rd;
    logic            regwrite;
  } ex_mem_t;

  function automatic logic is_mem_op(input logic [OPW-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and data memory.
interface mem_stage_if;
  import pipe_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/dmem_access_fsm.sv
// Data-memory access sequencer: request drive, wait counting, timeout and stall generation.
module dmem_access_fsm
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic start_we,
  input  logic ack,
  output logic req,
  output logic we,
  output logic stall,
  output logic timeout_now
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  // Ack in the last allowed cycle wins over the timeout.
  assign timeout_now = (state == ACCESS) && !ack && (cnt == CNT_LAST);
  assign stall       = (state == ACCESS) && !ack && !timeout_now;

  // A new access may start on the same edge the previous one completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= 1'b0;
      we    <= 1'b0;
    end else if (start) begin
      state <= ACCESS;
      cnt   <= '0;
      req   <= 1'b1;
      we    <= start_we;
    end else if (state == ACCESS) begin
      if (ack || timeout_now) begin
        state <= IDLE;
        req   <= 1'b0;
        we    <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM register, LW/SW data-memory access and MEM/WB register with forwarding outputs.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [OPW-1:0]    ex_aluop,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [REGW-1:0]   ex_rd,
  input  logic              ex_regwrite,
  output logic              mem_stall,
  output logic [REGW-1:0]   ex_mem_rd,
  output logic              ex_mem_regwrite,
  output logic [XLEN-1:0]   ex_mem_aluresult,
  output logic              ex_mem_is_load,
  output logic [REGW-1:0]   mem_wb_rd,
  output logic              mem_wb_regwrite,
  output logic [XLEN-1:0]   mem_wb_data,
  mem_stage_if.master       dmem,
  output logic              mem_fault
);

  ex_mem_t ex_mem;
  ex_mem_t ex_next;
  logic    ex_is_mem;
  logic    ex_aligned;
  logic    start;
  logic    misaligned;
  logic    timeout_now;

  assign ex_is_mem  = ex_valid && is_mem_op(ex_aluop);
  assign ex_aligned = (ex_result[1:0] == 2'b00);
  assign start      = !mem_stall && ex_is_mem && ex_aligned;
  assign misaligned = !mem_stall && ex_is_mem && !ex_aligned;

  // Stores and misaligned accesses never write back.
  always_comb begin
    ex_next          = '0;
    ex_next.valid    = ex_valid;
    ex_next.op       = ex_aluop;
    ex_next.result   = ex_result;
    ex_next.sdata    = ex_store_data;
    ex_next.rd       = ex_rd;
    ex_next.regwrite = ex_regwrite && ex_valid && (ex_rd != '0) &&
                       (ex_aluop != OP_SW) && !(ex_is_mem && !ex_aligned);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem <= '0;
    end else if (!mem_stall) begin
      ex_mem <= ex_next;
    end
  end

  dmem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_we    (ex_aluop == OP_SW),
    .ack         (dmem.ack),
    .req         (dmem.req),
    .we          (dmem.we),
    .stall       (mem_stall),
    .timeout_now (timeout_now)
  );

  assign dmem.addr  = ex_mem.result;
  assign dmem.wdata = ex_mem.sdata;

  assign ex_mem_rd        = ex_mem.rd;
  assign ex_mem_regwrite  = ex_mem.regwrite;
  assign ex_mem_aluresult = ex_mem.result;
  assign ex_mem_is_load   = ex_mem.valid && (ex_mem.op == OP_LW);

  // Stall inserts a bubble; an aborted access also retires as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wb_rd       <= '0;
      mem_wb_regwrite <= 1'b0;
      mem_wb_data     <= '0;
    end else if (mem_stall) begin
      mem_wb_regwrite <= 1'b0;
    end else begin
      mem_wb_rd       <= ex_mem.rd;
      mem_wb_regwrite <= ex_mem.regwrite && !timeout_now;
      mem_wb_data     <= ex_mem_is_load ? dmem.rdata : ex_mem.result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_fault <= 1'b0;
    end else if (misaligned || timeout_now) begin
      mem_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with TIMEOUT=4 and a hand-driven memory port.
module tb_mem_stage;
  import pipe_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic [4:0]      ex_aluop;
  logic [31:0]     ex_result;
  logic [31:0]     ex_store_data;
  logic [4:0]      ex_rd;
  logic            ex_regwrite;
  logic            mem_stall;
  logic [4:0]      ex_mem_rd;
  logic            ex_mem_regwrite;
  logic [31:0]     ex_mem_aluresult;
  logic            ex_mem_is_load;
  logic [4:0]      mem_wb_rd;
  logic            mem_wb_regwrite;
  logic [31:0]     mem_wb_data;
  logic            mem_fault;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cnt;

  mem_stage_if dmem_bus ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid         (ex_valid),
    .ex_aluop         (ex_aluop),
    .ex_result        (ex_result),
    .ex_store_data    (ex_store_data),
    .ex_rd            (ex_rd),
    .ex_regwrite      (ex_regwrite),
    .mem_stall        (mem_stall),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_regwrite  (ex_mem_regwrite),
    .ex_mem_aluresult (ex_mem_aluresult),
    .ex_mem_is_load   (ex_mem_is_load),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_regwrite  (mem_wb_regwrite),
    .mem_wb_data      (mem_wb_data),
    .dmem             (dmem_bus.master),
    .mem_fault        (mem_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw);
    ex_valid      = 1'b1;
    ex_aluop      = op;
    ex_result     = res;
    ex_store_data = sd;
    ex_rd         = rd;
    ex_regwrite   = rw;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_aluop = OP_ADD; ex_result = '0; ex_store_data = '0;
    ex_rd = '0; ex_regwrite = 1'b0;
    dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_stall",   32'(mem_stall), 32'd0);
    check("rst_req",     32'(dmem_bus.req), 32'd0);
    check("rst_exm_rd",  32'(ex_mem_rd), 32'd0);
    check("rst_wb_rw",   32'(mem_wb_regwrite), 32'd0);
    check("rst_fault",   32'(mem_fault), 32'd0);

    // ADD pass-through
    drive(OP_ADD, 32'h7, 32'h0, 5'd5, 1'b1);
    step();
    ex_valid = 1'b0;
    check("add_exm_rd",  32'(ex_mem_rd), 32'd5);
    check("add_exm_rw",  32'(ex_mem_regwrite), 32'd1);
    check("add_exm_res", ex_mem_aluresult, 32'h7);
    check("add_stall",   32'(mem_stall), 32'd0);
    step();
    check("add_wb_data", mem_wb_data, 32'h7);
    check("add_wb_rw",   32'(mem_wb_regwrite), 32'd1);
    check("add_wb_rd",   32'(mem_wb_rd), 32'd5);

    // LW zero wait
    drive(OP_LW, 32'h100, 32'h0, 5'd3, 1'b1);
    step();
    ex_valid = 1'b0;
    check("lw0_req",     32'(dmem_bus.req), 32'd1);
    check("lw0_we",      32'(dmem_bus.we), 32'd0);
    check("lw0_addr",    dmem_bus.addr, 32'h100);
    check("lw0_isload",  32'(ex_mem_is_load), 32'd1);
    dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'hDEADBEEF;
    #1;
    check("lw0_stall",   32'(mem_stall), 32'd0);
    step();
    dmem_bus.ack = 1'b0;
    check("lw0_wb_data", mem_wb_data, 32'hDEADBEEF);
    check("lw0_wb_rw",   32'(mem_wb_regwrite), 32'd1);
    check("lw0_wb_rd",   32'(mem_wb_rd), 32'd3);
    check("lw0_req_off", 32'(dmem_bus.req), 32'd0);

    // SW with 3 wait cycles; ack lands on the last allowed cycle
    drive(OP_SW, 32'h200, 32'h1234, 5'd7, 1'b1);
    step();
    ex_valid = 1'b0;
    check("sw_req",      32'(dmem_bus.req), 32'd1);
    check("sw_we",       32'(dmem_bus.we), 32'd1);
    check("sw_wdata",    dmem_bus.wdata, 32'h1234);
    check("sw_addr",     dmem_bus.addr, 32'h200);
    check("sw_exm_rw",   32'(ex_mem_regwrite), 32'd0);
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_bus.ack = (i == 3);
      #1;
      if (mem_stall) stall_cnt++;
      if (i < 3) step();
    end
    step();
    dmem_bus.ack = 1'b0;
    check("sw_stall_cyc", 32'(stall_cnt), 32'd3);
    check("sw_req_off",  32'(dmem_bus.req), 32'd0);
    check("sw_wb_rw",    32'(mem_wb_regwrite), 32'd0);
    check("sw_no_fault", 32'(mem_fault), 32'd0);

    // Misaligned LW
    drive(OP_LW, 32'h102, 32'h0, 5'd4, 1'b1);
    step();
    ex_valid = 1'b0;
    check("mis_req",     32'(dmem_bus.req), 32'd0);
    check("mis_fault",   32'(mem_fault), 32'd1);
    check("mis_exm_rw",  32'(ex_mem_regwrite), 32'd0);
    step();
    check("mis_wb_rw",   32'(mem_wb_regwrite), 32'd0);
    check("mis_req2",    32'(dmem_bus.req), 32'd0);

    // Reset clears the sticky fault
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_fault_clr", 32'(mem_fault), 32'd0);

    // Timeout: no ack ever
    drive(OP_LW, 32'h300, 32'h0, 5'd6, 1'b1);
    step();
    ex_valid = 1'b0;
    check("to_req",      32'(dmem_bus.req), 32'd1);
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_stall) stall_cnt++;
      step();
    end
    check("to_stall_cyc", 32'(stall_cnt), 32'd3);
    check("to_req_off",  32'(dmem_bus.req), 32'd0);
    check("to_fault",    32'(mem_fault), 32'd1);
    check("to_wb_rw",    32'(mem_wb_regwrite), 32'd0);
    drive(OP_ADD, 32'h55, 32'h0, 5'd9, 1'b1);
    step();
    ex_valid = 1'b0;
    step();
    check("to_add_data", mem_wb_data, 32'h55);
    check("to_add_rw",   32'(mem_wb_regwrite), 32'd1);
    check("to_sticky",   32'(mem_fault), 32'd1);

    // Reset during ACCESS, then a late ack
    drive(OP_LW, 32'h400, 32'h0, 5'd2, 1'b1);
    step();
    ex_valid = 1'b0;
    check("ra_req",      32'(dmem_bus.req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("ra_req_off",  32'(dmem_bus.req), 32'd0);
    check("ra_fault",    32'(mem_fault), 32'd0);
    check("ra_exm_res",  ex_mem_aluresult, 32'd0);
    check("ra_wb_data",  mem_wb_data, 32'd0);
    check("ra_wb_rd",    32'(mem_wb_rd), 32'd0);
    dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'hBAD0BAD0;
    #1;
    check("ra_stall",    32'(mem_stall), 32'd0);
    step();
    dmem_bus.ack = 1'b0;
    check("ra_late_rw",  32'(mem_wb_regwrite), 32'd0);
    check("ra_late_data", mem_wb_data, 32'd0);
    check("ra_late_req", 32'(dmem_bus.req), 32'd0);

    // ADD with rd=0 never writes back
    drive(OP_ADD, 32'h11, 32'h0, 5'd0, 1'b1);
    step();
    ex_valid = 1'b0;
    check("rd0_exm_rw",  32'(ex_mem_regwrite), 32'd0);
    step();
    check("rd0_wb_rw",   32'(mem_wb_regwrite), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
